serial_add_ctrl: RTL and testbench

- Bit-serial adder controller. Time-multiplexes a single 1-bit full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands.
- Handles the start/busy/done handshake, operand shift registers, the carry flop and the result register.
- Sits between a requesting master and the shared full-adder cell. Trades latency for area.

---
 rtl/serial_add_pkg.sv | 20 ++
 rtl/serial_add_ctrl_fa_cell.sv | 14 +
 rtl/serial_add_ctrl.sv | 140 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the bit-counter width helper.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Counter must hold 0..width without wrapping inside one operation.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full-adder cell shared across all bit positions of the
// serial adder. Purely combinational.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: time-multiplexes one fa_cell over WIDTH
// cycles to produce {cout,sum} = a + b + cin.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' input that turns
// the operation into a - b (b inverted, carry-in forced to 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  fa_cell u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Next sum shift-register value: new bit enters at the MSB, the rest move right.
  always_comb begin
    s_ext  = {fa_sum, s_sr};
    s_next = s_ext[WIDTH:1];
  end

  // Operand B / carry-in values loaded on an accepted start.
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end else begin
      b_load = b;
      c_load = cin;
    end
`else
    b_load = b;
    c_load = cin;
`endif
  end

  // Controller FSM with datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            s_sr  <= '0;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_next;
          carry <= fa_carry;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            sum   <= s_next;
            cout  <= fa_carry;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end
        S_DONE: begin
          // The result pulse lasts one cycle; a new request may be taken here.
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            s_sr  <= '0;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1).
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
  logic       sub1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int  edges;
  int  bcnt;
  bit  moved;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub1),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request before edge k, let edge k accept it, then drop start.
  task automatic kick(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb;
    cin   = tc;
`ifdef SERIAL_ADD_SUB_EN
    sub   = ts;
`else
    if (ts) start = 1'b1;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'hA5;
    b     = 8'h5A;
    cin   = ~tc;
  endtask

  // Bounded wait for done on the WIDTH=8 instance. edges counts edges after
  // the start edge; bcnt counts busy samples before done; moved flags any
  // sum change before completion.
  task automatic wait_done(input logic [7:0] hold);
    edges = 0;
    bcnt  = 0;
    moved = 1'b0;
    while (done !== 1'b1 && edges < 30) begin
      if (busy === 1'b1) bcnt++;
      if (sum !== hold) moved = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0; sub1 = 1'b0;
`endif
    #12;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (sum !== 8'h00) begin n_bad++; $display("FAIL reset_sum: got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b want 0", cout); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    kick(8'h3C, 8'h5A, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_k: got %b want 1", busy); end
    wait_done(8'h00);
    // done is registered at edge k+8, i.e. 8 edges after the start edge.
    n_cmp++; if (edges !== 8) begin n_bad++; $display("FAIL basic_latency: got %0d want 8", edges); end
    n_cmp++; if (bcnt !== 8) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 8", bcnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    n_cmp++; if (sum !== 8'h96) begin n_bad++; $display("FAIL basic_sum: got %h want 96", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL basic_cout: got %b want 0", cout); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: got %b want 0", done); end
    n_cmp++; if (sum !== 8'h96) begin n_bad++; $display("FAIL basic_sum_held: got %h want 96", sum); end
  endtask

  task automatic test_hold;
    kick(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(8'h96);
    n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL hold1_stable: got %b want 0", moved); end
    n_cmp++; if (sum !== 8'h00) begin n_bad++; $display("FAIL hold1_sum: got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL hold1_cout: got %b want 1", cout); end
    repeat (3) @(posedge clk);
    kick(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done(8'h00);
    n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL hold2_stable: got %b want 0", moved); end
    n_cmp++; if (edges !== 8) begin n_bad++; $display("FAIL hold2_latency: got %0d want 8", edges); end
    n_cmp++; if (sum !== 8'hFF) begin n_bad++; $display("FAIL hold2_sum: got %h want ff", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL hold2_cout: got %b want 1", cout); end
  endtask

  // start held high with operands changing every cycle; operand set at edge j
  // is a=j*16+1, b=j+2, cin=j[0]. Accepts land on edges 0, 9, 18, 27.
  task automatic test_back_to_back;
    logic [7:0] es;
    repeat (2) @(posedge clk);
    for (int j = 0; j < 28; j++) begin
      @(negedge clk);
      start = 1'b1;
      a     = 8'(j * 16 + 1);
      b     = 8'(j + 2);
      cin   = 1'(j % 2);
      @(posedge clk);
      #1;
      if (j == 8 || j == 17 || j == 26) begin
        case (j)
          8:       es = 8'h03;
          17:      es = 8'h9D;
          default: es = 8'h35;
        endcase
        n_cmp++;
        if (done !== 1'b1 || sum !== es || cout !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_result_e%0d: got done=%b sum=%h cout=%b want done=1 sum=%h cout=0", j, done, sum, cout, es);
        end
      end else begin
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_nodone_e%0d: got %b want 0", j, done); end
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic test_reset_mid_run;
    kick(8'h55, 8'h33, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstrun_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstrun_done: got %b want 0", done); end
    n_cmp++; if (sum !== 8'h00) begin n_bad++; $display("FAIL rstrun_sum: got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL rstrun_cout: got %b want 0", cout); end
    n_cmp++; if (u_dut8.state !== 2'd0) begin n_bad++; $display("FAIL rstrun_state: got %0d want 0", u_dut8.state); end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstrun_nopulse: got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstrun_idle: got done=%b busy=%b want 0 0", done, busy); end
    kick(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(8'h00);
    n_cmp++; if (edges !== 8) begin n_bad++; $display("FAIL rstrun_latency: got %0d want 8", edges); end
    n_cmp++; if (sum !== 8'h02) begin n_bad++; $display("FAIL rstrun_sum2: got %h want 02", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL rstrun_cout2: got %b want 0", cout); end
  endtask

  task automatic test_width1;
    int e1;
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL w1_busy: got %b want 1", busy1); end
    e1 = 0;
    while (done1 !== 1'b1 && e1 < 10) begin @(posedge clk); #1; e1++; end
    n_cmp++; if (e1 !== 1) begin n_bad++; $display("FAIL w1_latency: got %0d want 1", e1); end
    n_cmp++; if (sum1 !== 1'b1 || cout1 !== 1'b1) begin n_bad++; $display("FAIL w1_111: got sum=%b cout=%b want 1 1", sum1, cout1); end
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0;
    e1 = 0;
    while (done1 !== 1'b1 && e1 < 10) begin @(posedge clk); #1; e1++; end
    n_cmp++; if (e1 !== 1) begin n_bad++; $display("FAIL w1_latency2: got %0d want 1", e1); end
    n_cmp++; if (sum1 !== 1'b1 || cout1 !== 1'b0) begin n_bad++; $display("FAIL w1_010: got sum=%b cout=%b want 1 0", sum1, cout1); end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    repeat (2) @(posedge clk);
    kick(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done(8'h02);
    n_cmp++; if (sum !== 8'h0F) begin n_bad++; $display("FAIL sub1_sum: got %h want 0f", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL sub1_cout: got %b want 1", cout); end
    repeat (2) @(posedge clk);
    kick(8'h01, 8'h02, 1'b1, 1'b1);
    wait_done(8'h0F);
    n_cmp++; if (sum !== 8'hFF) begin n_bad++; $display("FAIL sub2_sum: got %h want ff", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL sub2_cout: got %b want 0", cout); end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
